result_writeback_unit: RTL and testbench

//  Write-side counterpart of the BRAM read sequencer: accepts a stream of compute

---
 rtl/result_writeback_unit.sv | 143 ++++++++++++++
 tb/tb_result_writeback_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/result_writeback_unit.sv
// ----------------------------------------------------------------------------
// result_writeback_unit
//
// Purpose:
//   Takes a stream of compute results over a valid/ready handshake and writes
//   one frame of 2^BRAM_DEPTH words into the result BRAM.
//   - Words land at addresses 0, 1, ... N-1, in order.
//   - A one-cycle done pulse tells the top-level controller the frame is
//     complete.
//
// Ports:
//   clk        system clock; all logic is on the rising edge
//   reset_n    asynchronous active-low reset
//   start      one-cycle request to begin a frame (honoured only in IDLE)
//   flush      abort the current frame and return to IDLE
//   in_valid   a result word is present on in_data
//   in_data    result word
//   in_ready   unit accepts a word this cycle (state WRITE)
//   bram_we    BRAM write enable
//   bram_addr  BRAM write address
//   bram_din   BRAM write data
//   busy       a frame is in progress (state WRITE)
//   done       one-cycle pulse while the last word is being written
//   drop_err   sticky flag: a word was offered while the unit was not accepting
// ----------------------------------------------------------------------------
module result_writeback_unit #(
    parameter int BRAM_DEPTH = 2,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  bram_we,
    output logic [BRAM_DEPTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    output logic                  busy,
    output logic                  done,
    output logic                  drop_err
);

    localparam logic [BRAM_DEPTH-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [BRAM_DEPTH-1:0] wr_ptr;
    logic [BRAM_DEPTH-1:0] wr_ptr_next;
    logic                  accept;
    logic                  start_taken;

    // in_ready depends only on the state register.
    // accept therefore never feeds back into the handshake.
    assign accept      = (state == ST_WRITE) && in_valid;
    assign start_taken = (state == ST_IDLE) && start && !flush;

    assign in_ready = (state == ST_WRITE);
    assign busy     = (state == ST_WRITE);
    assign done     = (state == ST_DONE);

    // Next-state and pointer logic.
    // flush overrides everything: it also kills an accept in the same cycle.
    always_comb begin
        state_next  = state;
        wr_ptr_next = wr_ptr;
        if (flush) begin
            state_next  = ST_IDLE;
            wr_ptr_next = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_next  = ST_WRITE;
                        wr_ptr_next = '0;
                    end
                end
                ST_WRITE: begin
                    if (accept) begin
                        wr_ptr_next = wr_ptr + BRAM_DEPTH'(1);
                        if (wr_ptr == LAST_ADDR) begin
                            state_next = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next  = ST_IDLE;
                    wr_ptr_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            wr_ptr <= '0;
        end else begin
            state  <= state_next;
            wr_ptr <= wr_ptr_next;
        end
    end

    // Write port: an accepted word reaches the BRAM exactly one cycle later.
    // Address and data hold their last value when nothing is written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_din  <= '0;
        end else begin
            bram_we <= accept && !flush;
            if (accept && !flush) begin
                bram_addr <= wr_ptr;
                bram_din  <= in_data;
            end
        end
    end

    // Sticky drop flag.
    // An honoured start opens a fresh frame, so it clears the flag even if a
    // word is also being offered in that cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_err <= 1'b0;
        end else if (start_taken) begin
            drop_err <= 1'b0;
        end else if (in_valid && (state != ST_WRITE)) begin
            drop_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_result_writeback_unit.sv
// ----------------------------------------------------------------------------
// tb_result_writeback_unit
//
// Purpose:
//   Directed, table-driven bench for result_writeback_unit with BRAM_DEPTH=2
//   and DATA_WIDTH=16.
//   - Each record holds the inputs for one cycle and the outputs expected
//     just after the following rising edge.
//   - Hand-written sequences cover the reset-state and mid-frame-reset cases.
// ----------------------------------------------------------------------------
module tb_result_writeback_unit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        bram_we;
    logic [1:0]  bram_addr;
    logic [15:0] bram_din;
    logic        busy;
    logic        done;
    logic        drop_err;

    int n_vec;
    int n_err;

    typedef struct {
        logic        start;
        logic        flush;
        logic        valid;
        logic [15:0] data;
        logic        we;
        logic [1:0]  addr;
        logic [15:0] din;
        logic        rdy;
        logic        bsy;
        logic        dn;
        logic        derr;
    } vec_t;

    vec_t vecs[$];

    result_writeback_unit #(
        .BRAM_DEPTH(2),
        .DATA_WIDTH(16)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .flush    (flush),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .bram_we  (bram_we),
        .bram_addr(bram_addr),
        .bram_din (bram_din),
        .busy     (busy),
        .done     (done),
        .drop_err (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic s, input logic f, input logic v,
                                input logic [15:0] d, input logic we,
                                input logic [1:0] a, input logic [15:0] di,
                                input logic r, input logic b, input logic dn,
                                input logic de);
        vec_t t;
        t.start = s; t.flush = f; t.valid = v; t.data = d;
        t.we = we; t.addr = a; t.din = di; t.rdy = r; t.bsy = b;
        t.dn = dn; t.derr = de;
        return t;
    endfunction

    task automatic checkOutput(input vec_t e, input string name);
        n_vec++;
        if (bram_we !== e.we || bram_addr !== e.addr || bram_din !== e.din ||
            in_ready !== e.rdy || busy !== e.bsy || done !== e.dn ||
            drop_err !== e.derr) begin
            n_err++;
            $display("[TB] FAIL %s: got we=%b addr=%0d din=%h rdy=%b busy=%b done=%b derr=%b, expected we=%b addr=%0d din=%h rdy=%b busy=%b done=%b derr=%b",
                     name, bram_we, bram_addr, bram_din, in_ready, busy, done, drop_err,
                     e.we, e.addr, e.din, e.rdy, e.bsy, e.dn, e.derr);
        end
    endtask

    // Drive one cycle of inputs and check the outputs just after the edge.
    task automatic applyStimulus(input vec_t v, input string name);
        start    = v.start;
        flush    = v.flush;
        in_valid = v.valid;
        in_data  = v.data;
        @(posedge clk);
        #1;
        checkOutput(v, name);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = 16'h0000;

        // Fields: start flush valid data | we addr din rdy busy done derr
        // Frame with in_valid held high.
        vecs.push_back(mk(1,0,0,16'h0000, 0,0,16'h0000, 1,1,0,0));
        vecs.push_back(mk(0,0,1,16'hA0A0, 1,0,16'hA0A0, 1,1,0,0));
        vecs.push_back(mk(0,0,1,16'hA1A1, 1,1,16'hA1A1, 1,1,0,0));
        vecs.push_back(mk(0,0,1,16'hA2A2, 1,2,16'hA2A2, 1,1,0,0));
        vecs.push_back(mk(0,0,1,16'hA3A3, 1,3,16'hA3A3, 0,0,1,0));
        vecs.push_back(mk(0,0,0,16'h0000, 0,3,16'hA3A3, 0,0,0,0));
        // Word offered in IDLE sets drop_err; the next start clears it.
        vecs.push_back(mk(0,0,1,16'h1234, 0,3,16'hA3A3, 0,0,0,1));
        vecs.push_back(mk(0,0,0,16'h0000, 0,3,16'hA3A3, 0,0,0,1));
        vecs.push_back(mk(1,0,0,16'h0000, 0,3,16'hA3A3, 1,1,0,0));
        // Toggled in_valid.
        vecs.push_back(mk(0,0,1,16'h0B00, 1,0,16'h0B00, 1,1,0,0));
        vecs.push_back(mk(0,0,0,16'hFFFF, 0,0,16'h0B00, 1,1,0,0));
        vecs.push_back(mk(0,0,1,16'h0B01, 1,1,16'h0B01, 1,1,0,0));
        vecs.push_back(mk(0,0,0,16'hFFFF, 0,1,16'h0B01, 1,1,0,0));
        vecs.push_back(mk(0,0,1,16'h0B02, 1,2,16'h0B02, 1,1,0,0));
        vecs.push_back(mk(0,0,0,16'hFFFF, 0,2,16'h0B02, 1,1,0,0));
        vecs.push_back(mk(0,0,1,16'h0B03, 1,3,16'h0B03, 0,0,1,0));
        vecs.push_back(mk(0,0,0,16'h0000, 0,3,16'h0B03, 0,0,0,0));
        // start re-pulsed mid-frame is ignored; addresses continue.
        vecs.push_back(mk(1,0,0,16'h0000, 0,3,16'h0B03, 1,1,0,0));
        vecs.push_back(mk(0,0,1,16'h0C00, 1,0,16'h0C00, 1,1,0,0));
        vecs.push_back(mk(0,0,1,16'h0C01, 1,1,16'h0C01, 1,1,0,0));
        vecs.push_back(mk(1,0,0,16'h0000, 0,1,16'h0C01, 1,1,0,0));
        vecs.push_back(mk(1,0,1,16'h0C02, 1,2,16'h0C02, 1,1,0,0));
        vecs.push_back(mk(0,0,1,16'h0C03, 1,3,16'h0C03, 0,0,1,0));
        // start plus a word during DONE: start ignored, drop_err set.
        vecs.push_back(mk(1,0,1,16'h9999, 0,3,16'h0C03, 0,0,0,1));
        // Flush after two accepts; the word offered with flush is discarded.
        vecs.push_back(mk(1,0,0,16'h0000, 0,3,16'h0C03, 1,1,0,0));
        vecs.push_back(mk(0,0,1,16'h0D00, 1,0,16'h0D00, 1,1,0,0));
        vecs.push_back(mk(0,0,1,16'h0D01, 1,1,16'h0D01, 1,1,0,0));
        vecs.push_back(mk(0,1,1,16'h0D02, 0,1,16'h0D01, 0,0,0,0));
        vecs.push_back(mk(0,0,0,16'h0000, 0,1,16'h0D01, 0,0,0,0));
        vecs.push_back(mk(1,0,0,16'h0000, 0,1,16'h0D01, 1,1,0,0));
        vecs.push_back(mk(0,0,1,16'h0E00, 1,0,16'h0E00, 1,1,0,0));
        // Flush with start in WRITE, then in IDLE: flush wins both times.
        vecs.push_back(mk(1,1,0,16'h0000, 0,0,16'h0E00, 0,0,0,0));
        vecs.push_back(mk(1,1,0,16'h0000, 0,0,16'h0E00, 0,0,0,0));
        vecs.push_back(mk(1,0,0,16'h0000, 0,0,16'h0E00, 1,1,0,0));
        vecs.push_back(mk(0,0,1,16'h5A5A, 1,0,16'h5A5A, 1,1,0,0));

        // Reset state, checked between edges before release.
        #12;
        checkOutput(mk(0,0,0,16'h0000, 0,0,16'h0000, 0,0,0,0), "reset_state");
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset mid-frame, asserted between edges.
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput(mk(0,0,0,16'h0000, 0,0,16'h0000, 0,0,0,0), "async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(mk(1,0,0,16'h0000, 0,0,16'h0000, 1,1,0,0), "post_reset_start");
        applyStimulus(mk(0,0,1,16'h7777, 1,0,16'h7777, 1,1,0,0), "post_reset_addr0");
        applyStimulus(mk(0,0,1,16'h7778, 1,1,16'h7778, 1,1,0,0), "post_reset_addr1");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
